cpu_alu16_seq: RTL and testbench

CPU_ALU16_SEQ -- requirements
Module: cpu_alu16_seq

---
 rtl/cpu_alu16_seq.sv | 128 ++++++++++++
 tb/tb_cpu_alu16_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu16_seq.sv
// Sequencer that runs a 16-bit add/subtract as two byte passes through an external 8-bit ALU.
// The low byte runs in LO and the high byte in HI, chained through the ALU carry/borrow.
module cpu_alu16_seq #(
    parameter logic [7:0] OPC_ADD = 8'h01,
    parameter logic [7:0] OPC_ADC = 8'h02,
    parameter logic [7:0] OPC_SUB = 8'h03,
    parameter logic [7:0] OPC_SBC = 8'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        carry_in,
    output logic [7:0]  alu_op_a,
    output logic [7:0]  alu_op_b,
    output logic [7:0]  alu_opcode,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_res,
    input  logic [7:0]  alu_flags,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  flags
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic [7:0]  res_lo_q, res_lo_d;
    logic        carry_q, carry_d;
    logic        zlo_q, zlo_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  flags_q, flags_d;

    // op[0] selects subtract, op[1] selects the carry/borrow-in variant.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        res_lo_d     = res_lo_q;
        carry_d      = carry_q;
        zlo_d        = zlo_q;
        result_d     = result_q;
        flags_d      = flags_q;
        alu_op_a     = 8'h00;
        alu_op_b     = 8'h00;
        alu_opcode   = OPC_ADD;
        alu_carry_in = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    op_d    = op;
                    a_d     = op_a;
                    b_d     = op_b;
                    cin_d   = carry_in;
                    state_d = StLo;
                end else begin
                    state_d = StIdle;
                end
            end
            StLo: begin
                busy         = 1'b1;
                alu_op_a     = a_q[7:0];
                alu_op_b     = b_q[7:0];
                alu_opcode   = op_q[1] ? (op_q[0] ? OPC_SBC : OPC_ADC)
                                       : (op_q[0] ? OPC_SUB : OPC_ADD);
                alu_carry_in = op_q[1] & cin_q;
                res_lo_d     = alu_res;
                carry_d      = alu_flags[0];
                zlo_d        = alu_flags[6];
                state_d      = StHi;
            end
            StHi: begin
                busy         = 1'b1;
                alu_op_a     = a_q[15:8];
                alu_op_b     = b_q[15:8];
                alu_opcode   = op_q[0] ? OPC_SBC : OPC_ADC;
                alu_carry_in = carry_q;
                result_d     = {alu_res, res_lo_q};
                // Zero must hold across both bytes, not just the high one.
                flags_d      = {alu_flags[7], zlo_q & alu_flags[6], alu_flags[5:0]};
                state_d      = StDone;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            cin_q    <= 1'b0;
            res_lo_q <= 8'h00;
            carry_q  <= 1'b0;
            zlo_q    <= 1'b0;
            result_q <= 16'h0000;
            flags_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            res_lo_q <= res_lo_d;
            carry_q  <= carry_d;
            zlo_q    <= zlo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_cpu_alu16_seq.sv
// Directed bench for cpu_alu16_seq; a behavioural 8-bit ALU closes the loop on the byte ports.
// Expected results and flags are hand-computed constants per vector.
module tb_cpu_alu16_seq;

    localparam logic [7:0] OPC_ADD = 8'h01;
    localparam logic [7:0] OPC_ADC = 8'h02;
    localparam logic [7:0] OPC_SUB = 8'h03;
    localparam logic [7:0] OPC_SBC = 8'h04;

    logic        clk = 1'b0;
    logic        reset, start, carry_in;
    logic [1:0]  op;
    logic [15:0] op_a, op_b, result;
    logic [7:0]  alu_op_a, alu_op_b, alu_opcode, alu_res, alu_flags, flags;
    logic        alu_carry_in, busy, done;

    int vectors = 0;
    int miscompares = 0;

    cpu_alu16_seq #(
        .OPC_ADD(OPC_ADD), .OPC_ADC(OPC_ADC), .OPC_SUB(OPC_SUB), .OPC_SBC(OPC_SBC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .carry_in(carry_in), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in), .alu_res(alu_res),
        .alu_flags(alu_flags), .busy(busy), .done(done), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    // Z80-style ALU: flags {S, Z, 0, H, 0, P/V, N, C}.
    logic       m_sub, m_c, m_v;
    logic [8:0] m_s;
    logic [4:0] m_h;
    always_comb begin
        m_sub = (alu_opcode == OPC_SUB) || (alu_opcode == OPC_SBC);
        m_c   = ((alu_opcode == OPC_ADC) || (alu_opcode == OPC_SBC)) ? alu_carry_in : 1'b0;
        if (m_sub) begin
            m_s = {1'b0, alu_op_a} - {1'b0, alu_op_b} - {8'h00, m_c};
            m_h = {1'b0, alu_op_a[3:0]} - {1'b0, alu_op_b[3:0]} - {4'h0, m_c};
            m_v = (alu_op_a[7] != alu_op_b[7]) && (m_s[7] != alu_op_a[7]);
        end else begin
            m_s = {1'b0, alu_op_a} + {1'b0, alu_op_b} + {8'h00, m_c};
            m_h = {1'b0, alu_op_a[3:0]} + {1'b0, alu_op_b[3:0]} + {4'h0, m_c};
            m_v = (alu_op_a[7] == alu_op_b[7]) && (m_s[7] != alu_op_a[7]);
        end
        alu_res   = m_s[7:0];
        alu_flags = {m_s[7], (m_s[7:0] == 8'h00), 1'b0, m_h[4], 1'b0, m_v, m_sub, m_s[8]};
    end

    // Snapshots taken by run_op.
    logic [7:0]  o_lo_opc, o_lo_a, o_lo_b, o_hi_opc, o_hi_a, o_hi_b, o_flags;
    logic        o_lo_cin, o_hi_cin, o_lo_busy, o_hi_busy, o_done, o_after_done, o_after_busy;
    logic [15:0] o_res;

    // Entered 1 time unit after a rising edge with the DUT idle; inputs are scrambled
    // after acceptance so any failure to latch shows up.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic c);
        op = o; op_a = a; op_b = b; carry_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; op_a = 16'hDEAD; op_b = 16'hBEEF; carry_in = ~c;
        o_lo_opc = alu_opcode; o_lo_a = alu_op_a; o_lo_b = alu_op_b;
        o_lo_cin = alu_carry_in; o_lo_busy = busy;
        @(posedge clk); #1;
        o_hi_opc = alu_opcode; o_hi_a = alu_op_a; o_hi_b = alu_op_b;
        o_hi_cin = alu_carry_in; o_hi_busy = busy;
        @(posedge clk); #1;
        o_done = done; o_res = result; o_flags = flags;
        @(posedge clk); #1;
        o_after_done = done; o_after_busy = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; op_a = 16'h0000; op_b = 16'h0000;
        carry_in = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy/done: got %b/%b expected 0/0", busy, done);
        end
        vectors++;
        if (result !== 16'h0000 || flags !== 8'h00) begin
            miscompares++;
            $display("FAIL reset result/flags: got %h/%h expected 0000/00", result, flags);
        end
        vectors++;
        if (alu_opcode !== OPC_ADD || alu_op_a !== 8'h00 || alu_op_b !== 8'h00
            || alu_carry_in !== 1'b0) begin
            miscompares++;
            $display("FAIL reset alu drive: got opc %h a %h b %h c %b expected 01 00 00 0",
                     alu_opcode, alu_op_a, alu_op_b, alu_carry_in);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [15:0] ta [5] = '{16'h12FF, 16'h0100, 16'h1200, 16'h7FFF, 16'h0001};
        logic [15:0] tb [5] = '{16'h0001, 16'hFF00, 16'h0000, 16'h0001, 16'h0001};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] tr [5] = '{16'h1300, 16'h0000, 16'h1200, 16'h8000, 16'h0002};
        logic [7:0]  tf [5] = '{8'h00, 8'h51, 8'h00, 8'h94, 8'h00};
        logic        th [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(2'b00, ta[i], tb[i], tc[i]);
            vectors++;
            if (o_lo_opc !== OPC_ADD || o_lo_cin !== 1'b0 || o_lo_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL add[%0d] lo: got opc %h cin %b busy %b expected 01 0 1",
                         i, o_lo_opc, o_lo_cin, o_lo_busy);
            end
            vectors++;
            if (o_lo_a !== ta[i][7:0] || o_lo_b !== tb[i][7:0] || o_hi_a !== ta[i][15:8]
                || o_hi_b !== tb[i][15:8]) begin
                miscompares++;
                $display("FAIL add[%0d] bytes: got %h %h %h %h expected %h %h %h %h", i,
                         o_lo_a, o_lo_b, o_hi_a, o_hi_b, ta[i][7:0], tb[i][7:0],
                         ta[i][15:8], tb[i][15:8]);
            end
            vectors++;
            if (o_hi_opc !== OPC_ADC || o_hi_cin !== th[i] || o_hi_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL add[%0d] hi: got opc %h cin %b busy %b expected 02 %b 1",
                         i, o_hi_opc, o_hi_cin, o_hi_busy, th[i]);
            end
            vectors++;
            if (o_done !== 1'b1 || o_res !== tr[i] || o_flags !== tf[i]) begin
                miscompares++;
                $display("FAIL add[%0d] done/result/flags: got %b %h %h expected 1 %h %h",
                         i, o_done, o_res, o_flags, tr[i], tf[i]);
            end
            vectors++;
            if (o_after_done !== 1'b0 || o_after_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL add[%0d] after done: got done %b busy %b expected 0 0",
                         i, o_after_done, o_after_busy);
            end
        end
    endtask

    task automatic test_sub();
        logic [15:0] ta [3] = '{16'h1000, 16'h0100, 16'h0005};
        logic [15:0] tb [3] = '{16'h0001, 16'h0100, 16'h0003};
        logic        tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] tr [3] = '{16'h0FFF, 16'h0000, 16'h0002};
        logic [7:0]  tf [3] = '{8'h12, 8'h42, 8'h02};
        logic        th [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(2'b01, ta[i], tb[i], tc[i]);
            vectors++;
            if (o_lo_opc !== OPC_SUB || o_lo_cin !== 1'b0) begin
                miscompares++;
                $display("FAIL sub[%0d] lo: got opc %h cin %b expected 03 0",
                         i, o_lo_opc, o_lo_cin);
            end
            vectors++;
            if (o_hi_opc !== OPC_SBC || o_hi_cin !== th[i]) begin
                miscompares++;
                $display("FAIL sub[%0d] hi: got opc %h cin %b expected 04 %b",
                         i, o_hi_opc, o_hi_cin, th[i]);
            end
            vectors++;
            if (o_done !== 1'b1 || o_res !== tr[i] || o_flags !== tf[i]) begin
                miscompares++;
                $display("FAIL sub[%0d] done/result/flags: got %b %h %h expected 1 %h %h",
                         i, o_done, o_res, o_flags, tr[i], tf[i]);
            end
        end
    endtask

    task automatic test_adc();
        logic [15:0] ta [2] = '{16'hFFFF, 16'h0001};
        logic [15:0] tb [2] = '{16'h0000, 16'h0001};
        logic        tc [2] = '{1'b1, 1'b0};
        logic [15:0] tr [2] = '{16'h0000, 16'h0002};
        logic [7:0]  tf [2] = '{8'h51, 8'h00};
        logic        th [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            run_op(2'b10, ta[i], tb[i], tc[i]);
            vectors++;
            if (o_lo_opc !== OPC_ADC || o_lo_cin !== tc[i]) begin
                miscompares++;
                $display("FAIL adc[%0d] lo: got opc %h cin %b expected 02 %b",
                         i, o_lo_opc, o_lo_cin, tc[i]);
            end
            vectors++;
            if (o_hi_opc !== OPC_ADC || o_hi_cin !== th[i]) begin
                miscompares++;
                $display("FAIL adc[%0d] hi: got opc %h cin %b expected 02 %b",
                         i, o_hi_opc, o_hi_cin, th[i]);
            end
            vectors++;
            if (o_res !== tr[i] || o_flags !== tf[i]) begin
                miscompares++;
                $display("FAIL adc[%0d] result/flags: got %h %h expected %h %h",
                         i, o_res, o_flags, tr[i], tf[i]);
            end
        end
    endtask

    task automatic test_sbc();
        logic [15:0] ta [2] = '{16'h0005, 16'h0000};
        logic [15:0] tb [2] = '{16'h0003, 16'h0000};
        logic [15:0] tr [2] = '{16'h0001, 16'hFFFF};
        logic [7:0]  tf [2] = '{8'h02, 8'h93};
        logic        th [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            run_op(2'b11, ta[i], tb[i], 1'b1);
            vectors++;
            if (o_lo_opc !== OPC_SBC || o_lo_cin !== 1'b1) begin
                miscompares++;
                $display("FAIL sbc[%0d] lo: got opc %h cin %b expected 04 1",
                         i, o_lo_opc, o_lo_cin);
            end
            vectors++;
            if (o_hi_opc !== OPC_SBC || o_hi_cin !== th[i]) begin
                miscompares++;
                $display("FAIL sbc[%0d] hi: got opc %h cin %b expected 04 %b",
                         i, o_hi_opc, o_hi_cin, th[i]);
            end
            vectors++;
            if (o_res !== tr[i] || o_flags !== tf[i]) begin
                miscompares++;
                $display("FAIL sbc[%0d] result/flags: got %h %h expected %h %h",
                         i, o_res, o_flags, tr[i], tf[i]);
            end
        end
    endtask

    task automatic test_ignore();
        op = 2'b00; op_a = 16'h0001; op_b = 16'h0002; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        op = 2'b01; op_a = 16'h5555; op_b = 16'h1111;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1 || alu_opcode !== OPC_ADC || alu_op_a !== 8'h00
            || alu_op_b !== 8'h00) begin
            miscompares++;
            $display("FAIL ignore hi: got busy %b opc %h a %h b %h expected 1 02 00 00",
                     busy, alu_opcode, alu_op_a, alu_op_b);
        end
        start = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1 || result !== 16'h0003 || flags !== 8'h00) begin
            miscompares++;
            $display("FAIL ignore done: got %b %h %h expected 1 0003 00", done, result, flags);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h0003) begin
            miscompares++;
            $display("FAIL ignore idle: got done %b busy %b result %h expected 0 0 0003",
                     done, busy, result);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        op = 2'b00; op_a = 16'h0101; op_b = 16'h0202; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;                         // LO of A
        op = 2'b01; op_a = 16'h1000; op_b = 16'h0001;
        @(posedge clk); #1;                         // HI of A
        vectors++;
        if (result !== 16'h0003) begin
            miscompares++;
            $display("FAIL b2b result held at lo exit: got %h expected 0003", result);
        end
        @(posedge clk); #1;                         // DONE of A
        pulses += int'(done);
        vectors++;
        if (done !== 1'b1 || result !== 16'h0303) begin
            miscompares++;
            $display("FAIL b2b first done: got %b %h expected 1 0303", done, result);
        end
        @(posedge clk); #1;                         // LO of B
        pulses += int'(done);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || alu_opcode !== OPC_SUB || alu_op_a !== 8'h00
            || alu_op_b !== 8'h01) begin
            miscompares++;
            $display("FAIL b2b second lo: got busy %b opc %h a %h b %h expected 1 03 00 01",
                     busy, alu_opcode, alu_op_a, alu_op_b);
        end
        @(posedge clk); #1;                         // HI of B
        pulses += int'(done);
        vectors++;
        if (result !== 16'h0303) begin
            miscompares++;
            $display("FAIL b2b result held in hi: got %h expected 0303", result);
        end
        @(posedge clk); #1;                         // DONE of B
        pulses += int'(done);
        vectors++;
        if (done !== 1'b1 || result !== 16'h0FFF || flags !== 8'h12) begin
            miscompares++;
            $display("FAIL b2b second done: got %b %h %h expected 1 0FFF 12",
                     done, result, flags);
        end
        @(posedge clk); #1;
        pulses += int'(done);
        vectors++;
        if (pulses !== 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b done pulses: got %0d busy %b expected 2 0", pulses, busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        op = 2'b00; op_a = 16'h12FF; op_b = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid pre: got busy %b expected 1", busy);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || flags !== 8'h00
            || alu_opcode !== OPC_ADD) begin
            miscompares++;
            $display("FAIL rstmid async: got busy %b done %b res %h flg %h opc %h expected 0 0 0000 00 01",
                     busy, done, result, flags, alu_opcode);
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pulses += int'(done);
        end
        vectors++;
        if (pulses !== 0 || result !== 16'h0000) begin
            miscompares++;
            $display("FAIL rstmid no done: got pulses %0d result %h expected 0 0000",
                     pulses, result);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = 2'b00; op_a = 16'h0001; op_b = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first start after reset: got busy %b expected 1", busy);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1 || result !== 16'h0002) begin
            miscompares++;
            $display("FAIL after reset op: got %b %h expected 1 0002", done, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_adc();
        test_sbc();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
